systolic_sequencer: RTL and testbench
=====================================

Name: systolic_sequencer

Overview:
Controls one matrix multiply, C = A x B, on the 2x2 output-stationary PE array.
- Latches both operand matrices when `start` is accepted.
- Clears the PE accumulators, then feeds skewed row (A) and column (B) streams into the array edges.
- Waits for the array to drain, then pulses `done` so the display/result-capture logic can read the PE outputs.
- Supports free-run mode and single-step mode; single-step advances one state per debounced button pulse, for board debug.

Parameters:
- DATA_W, 8, width of every operand and feed bus.
- DRAIN_CYCLES, 1, number of zero-feed cycles after the last operand before `done` (legal range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- start  in  1  request one multiply; sampled only in IDLE.
- step_mode  in  1  1 = advance only on `step`; 0 = free-run.
- step  in  1  single-cycle advance pulse, already synchronised and edge-detected upstream.
- a11, a12, a21, a22  in  DATA_W each  matrix A operands.
- b11, b12, b21, b22  in  DATA_W each  matrix B operands.
- row0_in, row1_in  out  DATA_W each  west-edge feed to PE rows 0 and 1.
- col0_in, col1_in  out  DATA_W each  north-edge feed to PE columns 0 and 1.
- pe_clr  out  1  synchronous accumulator clear to all PEs.
- pe_en  out  1  PE shift/accumulate enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- seq_state  out  4  current state encoding, for the display FSM.

Behaviour:
- Reset (async): state=IDLE, operand latches=0. All outputs are 0.
- Outputs are a pure decode of the state register and operand latches. There is no combinational path from any input to any output.
- "Advance" means: always true when step_mode=0; equals `step` when step_mode=1.
- step_mode is sampled every cycle. Changing it mid-operation takes effect on the next cycle.

State machine (encoding in brackets):
- IDLE [0]
  - Exit when start=1 and advance is true; go to CLEAR and latch a11..b22 that same edge.
  - start while busy is ignored and is not queued.
- CLEAR [1]
  - pe_clr=1, pe_en=0, feeds=0.
  - On advance, go to FEED0.
- FEED0 [2]
  - row0=a11, row1=0, col0=b11, col1=0.
- FEED1 [3]
  - row0=a12, row1=a21, col0=b21, col1=b12.
- FEED2 [4]
  - row0=0, row1=a22, col0=0, col1=b22.
- FEED0, FEED1 and FEED2 all drive pe_en=1, pe_clr=0, and go to the next state on advance.
- DRAIN [5]
  - pe_en=1, feeds=0.
  - An internal 4-bit counter loads DRAIN_CYCLES-1 on entry and decrements on each advance.
  - Go to DONE on an advance with counter=0.
- DONE [6]
  - done=1, pe_en=0, feeds=0.
  - Go to IDLE unconditionally on the next clock, regardless of step_mode.
- Unused encodings go to IDLE on the next clock with all outputs 0.
- Whenever advance is false, the state holds and outputs hold their state-decoded values. pe_en stays at its state value, so in step mode the PEs are clocked only when the state changes.
  - Exception: in step mode, pe_en is gated with advance, so PEs accumulate exactly once per step.

Timing and boundary cases:
- Free-run latency: start accepted at edge t gives CLEAR in cycle t+1, FEED0..FEED2 in t+2..t+4, DRAIN in t+5..t+4+DRAIN_CYCLES, and done=1 in cycle t+5+DRAIN_CYCLES.
- Operand inputs may change after acceptance without effect.
- start=1 held continuously: a new multiply begins on the first IDLE cycle after DONE (back-to-back, one IDLE cycle gap).
- Reset mid-operation: immediate return to IDLE with outputs 0. No done pulse.
- No arithmetic is performed here; feed values pass through at full DATA_W.

Decomposition:
- Shared package `sa_pkg`: state encodings (shared with display_control for seq_state decoding) and the DATA_W default.
- The DRAIN counter is inline.
- No sub-module; a single FSM is the natural partition.

Test Plan:
- Free-run, A=[[1,2],[3,4]], B=[[5,6],[7,8]], DRAIN_CYCLES=1, start pulsed at t:
  - pe_clr=1 at t+1.
  - Feeds (row0,row1,col0,col1) = (1,0,5,0) at t+2, (2,3,7,6) at t+3, (0,4,0,8) at t+4.
  - done=1 only at t+6.
  - With the PE model attached, C=[[19,22],[43,50]].
- start asserted during FEED1: ignored, exactly one done pulse, busy low for one cycle after DONE.
- step_mode=1, same operands, step pulsed every 5 cycles:
  - State advances only on step edges.
  - pe_en high for exactly 4 cycles total (3 feed + 1 drain).
  - Result again [[19,22],[43,50]].
- Reset asserted during FEED1: outputs 0 and seq_state=0 immediately (async). No done. A following start runs normally.
- DRAIN_CYCLES=3, free-run: done at t+8, with feeds zero during t+5..t+7.
- start held high for 20 cycles: done pulses repeat every 7 cycles (DRAIN_CYCLES=1), and the operands re-latch on each acceptance.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared definitions for the 2x2 systolic array controller and its display decoder.
package sa_pkg;

   localparam int unsigned SA_DATA_W = 8;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'd0,
      ST_CLEAR = 4'd1,
      ST_FEED0 = 4'd2,
      ST_FEED1 = 4'd3,
      ST_FEED2 = 4'd4,
      ST_DRAIN = 4'd5,
      ST_DONE  = 4'd6
   } seq_state_e;

endpackage

// File: rtl/systolic_sequencer.sv
// Sequences one C = A x B on the 2x2 output-stationary PE array: clear, skewed
// operand feed, drain, done pulse. Free-run or single-step operation.
module systolic_sequencer
   import sa_pkg::*;
#(
   parameter int unsigned DATA_W       = SA_DATA_W,
   parameter int unsigned DRAIN_CYCLES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              step_mode,
   input  logic              step,
   input  logic [DATA_W-1:0] a11,
   input  logic [DATA_W-1:0] a12,
   input  logic [DATA_W-1:0] a21,
   input  logic [DATA_W-1:0] a22,
   input  logic [DATA_W-1:0] b11,
   input  logic [DATA_W-1:0] b12,
   input  logic [DATA_W-1:0] b21,
   input  logic [DATA_W-1:0] b22,
   output logic [DATA_W-1:0] row0_in,
   output logic [DATA_W-1:0] row1_in,
   output logic [DATA_W-1:0] col0_in,
   output logic [DATA_W-1:0] col1_in,
   output logic              pe_clr,
   output logic              pe_en,
   output logic              busy,
   output logic              done,
   output logic [3:0]        seq_state
);

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   seq_state_e        state_q, state_d;
   logic [3:0]        drain_cnt_q, drain_cnt_d;
   logic [DATA_W-1:0] a_q [4];
   logic [DATA_W-1:0] a_d [4];
   logic [DATA_W-1:0] b_q [4];
   logic [DATA_W-1:0] b_d [4];
   logic [DATA_W-1:0] row0_q, row0_d, row1_q, row1_d;
   logic [DATA_W-1:0] col0_q, col0_d, col1_q, col1_d;
   logic              pe_clr_q, pe_clr_d, pe_en_q, pe_en_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              advance, pe_run;

   always_comb begin
      advance     = !step_mode || step;
      state_d     = state_q;
      drain_cnt_d = drain_cnt_q;
      a_d         = a_q;
      b_d         = b_q;

      case (state_q)
         ST_IDLE: begin
            if (start && advance) begin
               state_d = ST_CLEAR;
               a_d     = '{a11, a12, a21, a22};
               b_d     = '{b11, b12, b21, b22};
            end
         end
         ST_CLEAR: if (advance) state_d = ST_FEED0;
         ST_FEED0: if (advance) state_d = ST_FEED1;
         ST_FEED1: if (advance) state_d = ST_FEED2;
         ST_FEED2: begin
            if (advance) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = DRAIN_LOAD;
            end
         end
         ST_DRAIN: begin
            if (advance) begin
               if (drain_cnt_q == 4'd0) state_d = ST_DONE;
               else                     drain_cnt_d = drain_cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      // Array order: [0]=x11 [1]=x12 [2]=x21 [3]=x22.
      row0_d   = '0;
      row1_d   = '0;
      col0_d   = '0;
      col1_d   = '0;
      pe_clr_d = 1'b0;
      pe_run   = 1'b0;
      done_d   = 1'b0;
      case (state_d)
         ST_CLEAR: pe_clr_d = 1'b1;
         ST_FEED0: begin
            pe_run = 1'b1;
            row0_d = a_d[0];
            col0_d = b_d[0];
         end
         ST_FEED1: begin
            pe_run = 1'b1;
            row0_d = a_d[1];
            row1_d = a_d[2];
            col0_d = b_d[2];
            col1_d = b_d[1];
         end
         ST_FEED2: begin
            pe_run = 1'b1;
            row1_d = a_d[3];
            col1_d = b_d[3];
         end
         ST_DRAIN: pe_run = 1'b1;
         ST_DONE:  done_d = 1'b1;
         default: ;
      endcase

      // Enable only for the cycle following an advance, so each step
      // accumulates exactly once; in free-run advance is always true.
      pe_en_d = pe_run && advance;
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         drain_cnt_q <= '0;
         a_q         <= '{default: '0};
         b_q         <= '{default: '0};
         row0_q      <= '0;
         row1_q      <= '0;
         col0_q      <= '0;
         col1_q      <= '0;
         pe_clr_q    <= 1'b0;
         pe_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_cnt_q <= drain_cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         row0_q      <= row0_d;
         row1_q      <= row1_d;
         col0_q      <= col0_d;
         col1_q      <= col1_d;
         pe_clr_q    <= pe_clr_d;
         pe_en_q     <= pe_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign row0_in   = row0_q;
   assign row1_in   = row1_q;
   assign col0_in   = col0_q;
   assign col1_in   = col1_q;
   assign pe_clr    = pe_clr_q;
   assign pe_en     = pe_en_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign seq_state = state_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Bench for systolic_sequencer: behavioural 2x2 PE array, result scoreboard,
// cycle timeline checks for free-run, step mode, reset and long drain.
module tb_systolic_sequencer;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          reset, start1, start3, step_mode, step, sel;
   logic [DW-1:0] a11, a12, a21, a22, b11, b12, b21, b22;

   logic [DW-1:0] r0_1, r1_1, c0_1, c1_1, r0_3, r1_3, c0_3, c1_3;
   logic          clr_1, en_1, busy_1, done_1, clr_3, en_3, busy_3, done_3;
   logic [3:0]    st_1, st_3;

   logic [DW-1:0] m_r0, m_r1, m_c0, m_c1;
   logic          m_clr, m_en, m_busy, m_done;
   logic [3:0]    m_st;

   int unsigned   cyc = 0;
   int unsigned   n_checks = 0;
   int unsigned   n_fail = 0;
   int unsigned   en_cnt = 0;

   typedef struct packed {
      logic [31:0] c11, c12, c21, c22;
      logic [31:0] cyc;
   } exp_t;
   exp_t sb [$];

   logic [31:0]   acc [4];
   logic [DW-1:0] ar [2];
   logic [DW-1:0] br [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_sequencer #(.DATA_W(DW), .DRAIN_CYCLES(1)) dut (
      .clk(clk), .reset(reset), .start(start1), .step_mode(step_mode), .step(step),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .row0_in(r0_1), .row1_in(r1_1), .col0_in(c0_1), .col1_in(c1_1),
      .pe_clr(clr_1), .pe_en(en_1), .busy(busy_1), .done(done_1), .seq_state(st_1)
   );

   systolic_sequencer #(.DATA_W(DW), .DRAIN_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .step_mode(step_mode), .step(step),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .row0_in(r0_3), .row1_in(r1_3), .col0_in(c0_3), .col1_in(c1_3),
      .pe_clr(clr_3), .pe_en(en_3), .busy(busy_3), .done(done_3), .seq_state(st_3)
   );

   assign m_r0   = sel ? r0_3   : r0_1;
   assign m_r1   = sel ? r1_3   : r1_1;
   assign m_c0   = sel ? c0_3   : c0_1;
   assign m_c1   = sel ? c1_3   : c1_1;
   assign m_clr  = sel ? clr_3  : clr_1;
   assign m_en   = sel ? en_3   : en_1;
   assign m_busy = sel ? busy_3 : busy_1;
   assign m_done = sel ? done_3 : done_1;
   assign m_st   = sel ? st_3   : st_1;

   // PE(i,j) passes A east and B south; ar[i] is PE(i,0)'s A reg, br[j] is PE(0,j)'s B reg.
   always @(posedge clk) begin
      if (m_clr) begin
         for (int i = 0; i < 4; i++) acc[i] <= '0;
         for (int i = 0; i < 2; i++) begin
            ar[i] <= '0;
            br[i] <= '0;
         end
      end else if (m_en) begin
         acc[0] <= acc[0] + 32'(m_r0) * 32'(m_c0);
         acc[1] <= acc[1] + 32'(ar[0]) * 32'(m_c1);
         acc[2] <= acc[2] + 32'(m_r1) * 32'(br[0]);
         acc[3] <= acc[3] + 32'(ar[1]) * 32'(br[1]);
         ar[0]  <= m_r0;
         ar[1]  <= m_r1;
         br[0]  <= m_c0;
         br[1]  <= m_c1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [39:0] obs();
      return {m_st, m_clr, m_en, m_busy, m_done, m_r0, m_r1, m_c0, m_c1};
   endfunction

   function automatic logic [39:0] ev(input logic [3:0] st, input logic clr, input logic en,
                                      input logic bsy, input logic dn, input logic [7:0] r0,
                                      input logic [7:0] r1, input logic [7:0] c0, input logic [7:0] c1);
      return {st, clr, en, bsy, dn, r0, r1, c0, c1};
   endfunction

   task automatic push_exp(input int unsigned done_cyc);
      exp_t e;
      e.c11 = 32'(a11) * 32'(b11) + 32'(a12) * 32'(b21);
      e.c12 = 32'(a11) * 32'(b12) + 32'(a12) * 32'(b22);
      e.c21 = 32'(a21) * 32'(b11) + 32'(a22) * 32'(b21);
      e.c22 = 32'(a21) * 32'(b12) + 32'(a22) * 32'(b22);
      e.cyc = done_cyc;
      sb.push_back(e);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_en) en_cnt++;
         if (m_done) begin
            if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
            else begin
               e = sb.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.cyc));
               check("c11", 64'(acc[0]), 64'(e.c11));
               check("c12", 64'(acc[1]), 64'(e.c12));
               check("c21", 64'(acc[2]), 64'(e.c21));
               check("c22", 64'(acc[3]), 64'(e.c22));
            end
         end
      end
   endtask

   task automatic set_plan_ops();
      a11 = 8'd1; a12 = 8'd2; a21 = 8'd3; a22 = 8'd4;
      b11 = 8'd5; b12 = 8'd6; b21 = 8'd7; b22 = 8'd8;
   endtask

   task automatic rand_ops();
      a11 = 8'($urandom); a12 = 8'($urandom); a21 = 8'($urandom); a22 = 8'($urandom);
      b11 = 8'($urandom); b12 = 8'($urandom); b21 = 8'($urandom); b22 = 8'($urandom);
   endtask

   // Call just after a negedge; returns the cycle number seen right after the accepting edge.
   task automatic pulse_start(input bit use3, input bit do_push, output int unsigned t);
      if (use3) start3 = 1'b1;
      else      start1 = 1'b1;
      @(posedge clk);
      #1;
      t = cyc;
      if (do_push) push_exp(t + 4 + (use3 ? 3 : 1));
      start1 = 1'b0;
      start3 = 1'b0;
   endtask

   logic [39:0] tl [7];
   int unsigned t, en_base;
   logic [3:0]  prev_st;

   initial begin
      reset = 1'b1; start1 = 1'b0; start3 = 1'b0; step_mode = 1'b0; step = 1'b0; sel = 1'b0;
      set_plan_ops();
      fork monitor(); join_none

      // Reset state of both instances
      repeat (3) @(negedge clk);
      check("rst_dut1", 64'(obs()), 64'd0);
      sel = 1'b1;
      #1 check("rst_dut3", 64'(obs()), 64'd0);
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Free-run plan operands, cycle-exact timeline; operands scrambled after acceptance
      tl[0] = ev(4'd1, 1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
      tl[1] = ev(4'd2, 0, 1, 1, 0, 8'd1, 8'd0, 8'd5, 8'd0);
      tl[2] = ev(4'd3, 0, 1, 1, 0, 8'd2, 8'd3, 8'd7, 8'd6);
      tl[3] = ev(4'd4, 0, 1, 1, 0, 8'd0, 8'd4, 8'd0, 8'd8);
      tl[4] = ev(4'd5, 0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0);
      tl[5] = ev(4'd6, 0, 0, 1, 1, 8'd0, 8'd0, 8'd0, 8'd0);
      tl[6] = ev(4'd0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0, 8'd0);
      pulse_start(1'b0, 1'b1, t);
      rand_ops();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check($sformatf("timeline_k%0d", k), 64'(obs()), 64'(tl[k]));
      end

      // start during FEED1 is dropped
      rand_ops();
      pulse_start(1'b0, 1'b1, t);
      repeat (3) @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      check("busy_after_done", 64'(m_busy), 64'd0);
      @(negedge clk);
      check("no_queued_start", 64'({m_busy, m_st}), 64'd0);

      // Single-step mode, step every 5 cycles
      set_plan_ops();
      step_mode = 1'b1;
      start1    = 1'b1;
      en_base   = en_cnt;
      prev_st   = 4'd0;
      for (int s = 0; s < 6; s++) begin
         repeat (4) @(negedge clk);
         check($sformatf("step_hold%0d", s), 64'(m_st), 64'(prev_st));
         step = 1'b1;
         @(posedge clk);
         #1;
         start1 = 1'b0;
         if (s == 5) push_exp(cyc);
         @(negedge clk);
         step = 1'b0;
         prev_st = 4'(s + 1);
         check($sformatf("step_adv%0d", s), 64'(m_st), 64'(prev_st));
      end
      @(negedge clk);
      check("step_done_to_idle", 64'(m_st), 64'd0);
      check("step_pe_en_count", 64'(en_cnt - en_base), 64'd4);
      step_mode = 1'b0;

      // Async reset during FEED1, then a normal run
      rand_ops();
      pulse_start(1'b0, 1'b0, t);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_outputs", 64'(obs()), 64'd0);
      check("rst_mid_state", 64'(m_st), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      rand_ops();
      pulse_start(1'b0, 1'b1, t);
      repeat (7) @(negedge clk);

      // DRAIN_CYCLES=3 instance
      sel = 1'b1;
      rand_ops();
      pulse_start(1'b1, 1'b1, t);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k >= 4 && k <= 6)
            check($sformatf("drain3_k%0d", k), 64'(obs()), 64'(ev(4'd5, 0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 8'd0)));
         if (k == 7) check("drain3_done_state", 64'(m_st), 64'd6);
      end
      sel = 1'b0;
      @(negedge clk);

      // start held 20 cycles: acceptances every 7 edges, operands changing every cycle
      for (int c = 0; c < 20; c++) begin
         rand_ops();
         start1 = 1'b1;
         @(posedge clk);
         #1;
         if (c % 7 == 0) push_exp(cyc + 5);
         @(negedge clk);
      end
      start1 = 1'b0;
      repeat (10) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
